// File: rtl/cl_ocl_axil_reg_bank.sv
// AXI-Lite slave register bank: NUM_REGS RW scratch registers plus CYCLE_CNT and WR_CNT status counters.
// Define CL_OCL_AXIL_WR_TIMEOUT_EN to abandon a write whose missing AW/W half never arrives.
module cl_ocl_axil_reg_bank #(
    parameter int unsigned NUM_REGS   = 8,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0500,
    parameter int unsigned WR_TIMEOUT = 255
) (
    input  logic                   clk_main_a0,
    input  logic                   rst_main_sync,
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [31:0]            s_awaddr,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    input  logic [31:0]            s_wdata,
    input  logic [3:0]             s_wstrb,
    output logic                   s_bvalid,
    input  logic                   s_bready,
    output logic [1:0]             s_bresp,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    input  logic [31:0]            s_araddr,
    output logic                   s_rvalid,
    input  logic                   s_rready,
    output logic [31:0]            s_rdata,
    output logic [1:0]             s_rresp,
    output logic [NUM_REGS*32-1:0] reg_out,
    output logic [15:0]            vled_out
);

    localparam int unsigned DW = 32;
    localparam int unsigned IW = 30;
    localparam int unsigned BYTES = 4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF;

    if (NUM_REGS < 2 || NUM_REGS > 64 || ADDR_BASE[1:0] != 2'b00 || WR_TIMEOUT > 65535) begin : g_param_check
        $error("cl_ocl_axil_reg_bank: parameter out of range");
    end

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic [NUM_REGS*DW-1:0] regs;
    logic [DW-1:0]          cycle_cnt;
    logic [DW-1:0]          wr_cnt;

    logic [31:0]            aw_addr_q;
    logic [DW-1:0]          w_data_q;
    logic [BYTES-1:0]       w_strb_q;

`ifdef CL_OCL_AXIL_WR_TIMEOUT_EN
    logic [15:0]            wr_timer;
`endif

    logic                   aw_hs_c;
    logic                   w_hs_c;
    logic                   ar_hs_c;
    logic                   wr_commit_c;
    logic                   wr_hit_c;
    logic [31:0]            wr_addr_c;
    logic [DW-1:0]          wr_data_c;
    logic [BYTES-1:0]       wr_strb_c;
    logic [IW-1:0]          wr_idx_c;
    logic [IW-1:0]          rd_idx_c;
    logic                   rd_err_c;
    logic [DW-1:0]          rd_val_c;

    // Merge the latched half with the live half; decode the write target.
    always_comb begin
        aw_hs_c     = s_awvalid && s_awready;
        w_hs_c      = s_wvalid && s_wready;
        wr_addr_c   = (wr_state == WR_WAIT_W)  ? aw_addr_q : s_awaddr;
        wr_data_c   = (wr_state == WR_WAIT_AW) ? w_data_q  : s_wdata;
        wr_strb_c   = (wr_state == WR_WAIT_AW) ? w_strb_q  : s_wstrb;
        wr_commit_c = 1'b0;
        case (wr_state)
            WR_IDLE:    wr_commit_c = aw_hs_c && w_hs_c;
            WR_WAIT_W:  wr_commit_c = w_hs_c;
            WR_WAIT_AW: wr_commit_c = aw_hs_c;
            default:    wr_commit_c = 1'b0;
        endcase
        wr_idx_c = IW'((wr_addr_c - ADDR_BASE) >> 2);
        wr_hit_c = (wr_addr_c[1:0] == 2'b00) && (wr_addr_c >= ADDR_BASE) &&
                   (wr_idx_c < IW'(NUM_REGS));
    end

    // Read decode and data mux; sees register values from before any same-edge write.
    always_comb begin
        ar_hs_c  = s_arvalid && s_arready;
        rd_idx_c = IW'((s_araddr - ADDR_BASE) >> 2);
        rd_err_c = (s_araddr[1:0] != 2'b00) || (s_araddr < ADDR_BASE) ||
                   (rd_idx_c > IW'(NUM_REGS + 1));
        rd_val_c = RD_ERR_DATA;
        if (!rd_err_c) begin
            if (rd_idx_c == IW'(NUM_REGS)) begin
                rd_val_c = cycle_cnt;
            end else if (rd_idx_c == IW'(NUM_REGS + 1)) begin
                rd_val_c = wr_cnt;
            end else begin
                rd_val_c = '0;
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    if (rd_idx_c == IW'(i)) begin
                        rd_val_c = regs[DW*i +: DW];
                    end
                end
            end
        end
    end

    // Write FSM, register commit and WR_CNT.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            wr_state  <= WR_IDLE;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            regs      <= '0;
            wr_cnt    <= '0;
`ifdef CL_OCL_AXIL_WR_TIMEOUT_EN
            wr_timer  <= '0;
`endif
        end else begin
            case (wr_state)
                WR_IDLE, WR_WAIT_W, WR_WAIT_AW: begin
                    if (wr_commit_c) begin
                        wr_state  <= WR_RESP;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                        s_bvalid  <= 1'b1;
                        s_bresp   <= wr_hit_c ? RESP_OKAY : RESP_SLVERR;
                    end else if (wr_state == WR_IDLE && aw_hs_c) begin
                        wr_state  <= WR_WAIT_W;
                        aw_addr_q <= s_awaddr;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b1;
                    end else if (wr_state == WR_IDLE && w_hs_c) begin
                        wr_state  <= WR_WAIT_AW;
                        w_data_q  <= s_wdata;
                        w_strb_q  <= s_wstrb;
                        s_awready <= 1'b1;
                        s_wready  <= 1'b0;
`ifdef CL_OCL_AXIL_WR_TIMEOUT_EN
                    end else if (wr_state != WR_IDLE && wr_timer == 16'(WR_TIMEOUT)) begin
                        wr_state  <= WR_RESP;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                        s_bvalid  <= 1'b1;
                        s_bresp   <= RESP_SLVERR;
`endif
                    end else if (wr_state == WR_IDLE) begin
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                    end
`ifdef CL_OCL_AXIL_WR_TIMEOUT_EN
                    wr_timer <= (wr_state == WR_IDLE) ? 16'd0 : wr_timer + 16'd1;
`endif
                end
                WR_RESP: begin
                    if (s_bready) begin
                        wr_state  <= WR_IDLE;
                        s_bvalid  <= 1'b0;
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase

            if (wr_commit_c && wr_hit_c) begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    for (int b = 0; b < int'(BYTES); b++) begin
                        if (wr_idx_c == IW'(i) && wr_strb_c[b]) begin
                            regs[DW*i + 8*b +: 8] <= wr_data_c[8*b +: 8];
                        end
                    end
                end
                if (wr_cnt != '1) begin
                    wr_cnt <= wr_cnt + 32'd1;
                end
            end
        end
    end

    // Read FSM: data captured on the AR handshake edge, held until rready.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            rd_state  <= RD_IDLE;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
        end else if (rd_state == RD_IDLE) begin
            if (ar_hs_c) begin
                rd_state  <= RD_RESP;
                s_arready <= 1'b0;
                s_rvalid  <= 1'b1;
                s_rdata   <= rd_val_c;
                s_rresp   <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
            end else begin
                s_arready <= 1'b1;
            end
        end else if (s_rready) begin
            rd_state  <= RD_IDLE;
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
        end
    end

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign reg_out  = regs;
    assign vled_out = regs[15:0];

endmodule

// File: tb/tb_cl_ocl_axil_reg_bank.sv
// Bench for cl_ocl_axil_reg_bank: transaction-level model checked every cycle plus directed literal checks.
module tb_cl_ocl_axil_reg_bank;

    localparam int unsigned NR   = 8;
    localparam logic [31:0] BASE = 32'h0000_0500;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
    logic          s_bready = 1'b1, s_rready = 1'b1;
    logic [31:0]   s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]    s_wstrb = '0;
    logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]    s_bresp, s_rresp;
    logic [31:0]   s_rdata;
    logic [NR*32-1:0] reg_out;
    logic [15:0]   vled_out;

    always #5 clk = ~clk;

    cl_ocl_axil_reg_bank #(.NUM_REGS(NR), .ADDR_BASE(BASE), .WR_TIMEOUT(255)) dut (
        .clk_main_a0(clk), .rst_main_sync(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .reg_out(reg_out), .vled_out(vled_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no handshake within bound at %0t", nm, $time);
    endtask

    // 0 = RW reg, 1 = CYCLE_CNT, 2 = WR_CNT, 3 = decode error
    function automatic int m_kind(input logic [31:0] a);
        logic [31:0] idx;
        if (a[1:0] != 2'b00 || a < BASE) return 3;
        idx = (a - BASE) / 4;
        if (idx < 32'(NR)) return 0;
        if (idx == 32'(NR)) return 1;
        if (idx == 32'(NR + 1)) return 2;
        return 3;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [31:0] m_regs [NR];
    logic [31:0] m_wr_cnt = '0, m_cyc = '0;
    logic        rst_last = 1'b1;
    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0, p_b = 1'b0, p_r = 1'b0;
    logic        have_aw = 1'b0, have_w = 1'b0, in_resp = 1'b0, rd_busy = 1'b0;
    logic [31:0] n_awaddr = '0, n_wdata = '0, n_rdata = '0;
    logic [3:0]  n_wstrb = '0;
    logic [1:0]  n_rresp = '0;
    logic [31:0] q_awaddr = '0, q_wdata = '0, rd_exp_data = '0;
    logic [3:0]  q_wstrb = '0;
    logic [1:0]  exp_bresp = '0, rd_exp_resp = '0;

    always @(negedge clk) begin
        logic [255:0] flat;
        int k;
        if (rst_last) begin
            for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
            m_wr_cnt = '0; m_cyc = '0;
            have_aw = 1'b0; have_w = 1'b0; in_resp = 1'b0; rd_busy = 1'b0;
            chk("rst_awready", s_awready, 0);
            chk("rst_wready", s_wready, 0);
            chk("rst_arready", s_arready, 0);
            chk("rst_bvalid", s_bvalid, 0);
            chk("rst_rvalid", s_rvalid, 0);
            chk("rst_rdata", s_rdata, 0);
            chk("rst_reg_out", reg_out, 0);
        end else begin
            m_cyc = m_cyc + 32'd1;
            if (p_b) in_resp = 1'b0;
            if (p_r) rd_busy = 1'b0;
            if (p_aw) begin have_aw = 1'b1; q_awaddr = n_awaddr; end
            if (p_w)  begin have_w = 1'b1; q_wdata = n_wdata; q_wstrb = n_wstrb; end
            if (p_ar) begin rd_busy = 1'b1; rd_exp_data = n_rdata; rd_exp_resp = n_rresp; end
            if (have_aw && have_w) begin
                if (m_kind(q_awaddr) == 0) begin
                    k = int'((q_awaddr - BASE) / 4);
                    for (int b = 0; b < 4; b++)
                        if (q_wstrb[b]) m_regs[k][8*b +: 8] = q_wdata[8*b +: 8];
                    if (m_wr_cnt != 32'hFFFF_FFFF) m_wr_cnt = m_wr_cnt + 32'd1;
                    exp_bresp = 2'b00;
                end else begin
                    exp_bresp = 2'b10;
                end
                have_aw = 1'b0; have_w = 1'b0; in_resp = 1'b1;
            end
            chk("bvalid", s_bvalid, in_resp);
            if (in_resp) chk("bresp", s_bresp, exp_bresp);
            chk("awready", s_awready, !in_resp && !have_aw);
            chk("wready", s_wready, !in_resp && !have_w);
            chk("rvalid", s_rvalid, rd_busy);
            if (rd_busy) begin
                chk("rdata", s_rdata, rd_exp_data);
                chk("rresp", s_rresp, rd_exp_resp);
            end
            chk("arready", s_arready, !rd_busy);
            for (int i = 0; i < int'(NR); i++) flat[32*i +: 32] = m_regs[i];
            chk("reg_out", reg_out, flat);
            chk("vled_out", vled_out, m_regs[0][15:0]);
        end
        // handshakes that the coming edge will complete
        p_aw = !rst && s_awvalid && s_awready;
        p_w  = !rst && s_wvalid && s_wready;
        p_ar = !rst && s_arvalid && s_arready;
        p_b  = !rst && s_bvalid && s_bready;
        p_r  = !rst && s_rvalid && s_rready;
        n_awaddr = s_awaddr; n_wdata = s_wdata; n_wstrb = s_wstrb;
        if (p_ar) begin
            n_rresp = 2'b00;
            case (m_kind(s_araddr))
                0: n_rdata = m_regs[int'((s_araddr - BASE) / 4)];
                1: n_rdata = m_cyc;
                2: n_rdata = m_wr_cnt;
                default: begin n_rdata = 32'hDEAD_BEEF; n_rresp = 2'b10; end
            endcase
        end
        rst_last = rst;
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_aw(input logic [31:0] a);
        bit done = 1'b0;
        s_awaddr = a; s_awvalid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (s_awready) begin @(posedge clk); #1; done = 1'b1; end
        end
        s_awvalid = 1'b0;
        if (!done) tmo("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit done = 1'b0;
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (s_wready) begin @(posedge clk); #1; done = 1'b1; end
        end
        s_wvalid = 1'b0;
        if (!done) tmo("w_handshake");
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit done = 1'b0;
        s_araddr = a; s_arvalid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (s_arready) begin @(posedge clk); #1; done = 1'b1; end
        end
        s_arvalid = 1'b0;
        if (!done) tmo("ar_handshake");
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dly, input int w_dly, output logic [1:0] br);
        bit done = 1'b0;
        fork
            begin tick(aw_dly); send_aw(a); end
            begin tick(w_dly); send_w(d, s); end
        join
        br = 2'b11;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (s_bvalid && s_bready) begin br = s_bresp; @(posedge clk); #1; done = 1'b1; end
        end
        if (!done) tmo("b_handshake");
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        bit done = 1'b0;
        send_ar(a);
        d = '0; r = 2'b11;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (s_rvalid && s_rready) begin d = s_rdata; r = s_rresp; @(posedge clk); #1; done = 1'b1; end
        end
        if (!done) tmo("r_handshake");
    endtask

    // ---------------- directed sequence ----------------
    logic [1:0]  br, rr;
    logic [31:0] rdv;

    initial begin
        tick(3);
        chk("lit_rst_awready", s_awready, 0);
        chk("lit_rst_reg_out", reg_out, 0);
        rst = 1'b0;
        tick(1);
        chk("lit_post_rst_awready", s_awready, 1);
        chk("lit_post_rst_wready", s_wready, 1);
        chk("lit_post_rst_arready", s_arready, 1);

        wr(32'h500, 32'hCAFE_F00D, 4'hF, 0, 0, br);
        chk("lit_wr500_bresp", br, 2'b00);
        chk("lit_reg0", reg_out[31:0], 32'hCAFE_F00D);
        chk("lit_vled", vled_out, 16'hF00D);
        rd(32'h500, rdv, rr);
        chk("lit_rd500_data", rdv, 32'hCAFE_F00D);
        chk("lit_rd500_resp", rr, 2'b00);

        wr(32'h504, 32'h1122_3344, 4'b0101, 3, 0, br);
        chk("lit_w_first_bresp", br, 2'b00);
        chk("lit_reg1_strb", reg_out[63:32], 32'h0022_0044);
        wr(32'h508, 32'hA5A5_0003, 4'hF, 0, 5, br);
        chk("lit_aw_first_bresp", br, 2'b00);
        chk("lit_reg2", reg_out[95:64], 32'hA5A5_0003);

        wr(32'h520, 32'h1234_5678, 4'hF, 0, 0, br);
        chk("lit_wr_cyc_bresp", br, 2'b10);
        wr(32'h524, 32'h1234_5678, 4'hF, 0, 0, br);
        chk("lit_wr_wrcnt_bresp", br, 2'b10);
        wr(32'h52C, 32'h1234_5678, 4'hF, 0, 0, br);
        chk("lit_wr_oob_bresp", br, 2'b10);
        wr(32'h501, 32'h1234_5678, 4'hF, 0, 0, br);
        chk("lit_wr_unaligned_bresp", br, 2'b10);
        wr(32'h4FC, 32'h1234_5678, 4'hF, 0, 0, br);
        chk("lit_wr_below_bresp", br, 2'b10);
        chk("lit_reg0_untouched", reg_out[31:0], 32'hCAFE_F00D);
        wr(32'h50C, 32'hFFFF_FFFF, 4'h0, 0, 0, br);
        chk("lit_strb0_bresp", br, 2'b00);
        chk("lit_strb0_reg3", reg_out[127:96], 32'h0);

        rd(32'h52C, rdv, rr);
        chk("lit_rd_oob_data", rdv, 32'hDEAD_BEEF);
        chk("lit_rd_oob_resp", rr, 2'b10);
        rd(32'h502, rdv, rr);
        chk("lit_rd_unaligned_data", rdv, 32'hDEAD_BEEF);
        chk("lit_rd_unaligned_resp", rr, 2'b10);
        rd(32'h4FC, rdv, rr);
        chk("lit_rd_below_resp", rr, 2'b10);
        rd(32'h524, rdv, rr);
        chk("lit_wr_cnt_4", rdv, 32'd4);
        chk("lit_wr_cnt_resp", rr, 2'b00);
        rd(32'h51C, rdv, rr);
        chk("lit_rd_last_rw", rdv, 32'h0);
        rd(32'h520, rdv, rr);
        chk("lit_rd_cyc_resp", rr, 2'b00);

        s_rready = 1'b0;
        fork
            begin rd(32'h500, rdv, rr); end
            begin tick(10); s_rready = 1'b1; end
        join
        chk("lit_rready_hold_data", rdv, 32'hCAFE_F00D);

        s_bready = 1'b0;
        fork
            begin wr(32'h51C, 32'h0000_7777, 4'hF, 0, 0, br); end
            begin tick(8); s_bready = 1'b1; end
        join
        chk("lit_bready_hold_bresp", br, 2'b00);
        chk("lit_reg7", reg_out[255:224], 32'h0000_7777);

        wr(32'h504, 32'h0000_0005, 4'hF, 0, 0, br);
        fork
            begin wr(32'h504, 32'hFFFF_FFFF, 4'hF, 0, 0, br); end
            begin rd(32'h504, rdv, rr); end
        join
        chk("lit_collision_old", rdv, 32'h0000_0005);
        rd(32'h504, rdv, rr);
        chk("lit_collision_new", rdv, 32'hFFFF_FFFF);
        rd(32'h524, rdv, rr);
        chk("lit_wr_cnt_7", rdv, 32'd7);

        // park both FSMs in their response states, then reset
        s_bready = 1'b0; s_rready = 1'b0;
        s_awaddr = 32'h500; s_awvalid = 1'b1;
        s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_araddr = 32'h504; s_arvalid = 1'b1;
        tick(1);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        tick(2);
        chk("lit_parked_bvalid", s_bvalid, 1);
        chk("lit_parked_rvalid", s_rvalid, 1);
        rst = 1'b1;
        tick(1);
        chk("lit_midrst_bvalid", s_bvalid, 0);
        chk("lit_midrst_rvalid", s_rvalid, 0);
        chk("lit_midrst_reg_out", reg_out, 0);
        tick(1);
        rst = 1'b0; s_bready = 1'b1; s_rready = 1'b1;
        tick(2);
        rd(32'h500, rdv, rr);
        chk("lit_after_rst_reg0", rdv, 32'h0);
        rd(32'h524, rdv, rr);
        chk("lit_after_rst_wr_cnt", rdv, 32'h0);

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cl_ocl_axil_reg_bank.md
Name: cl_ocl_axil_reg_bank

Overview:
AXI-Lite slave register bank that consumes the master side of the OCL AXI-Lite register slice. It decodes single-beat BAR0 accesses into a bank of RW scratch registers plus two read-only status counters. AW and W may arrive in any order or in the same cycle. It drives the virtual-LED source and exports the register contents to downstream CL logic.

Parameters:
NUM_REGS, 8, number of 32-bit RW registers (2..64)
ADDR_BASE, 32'h0000_0500, byte address of register 0 (word aligned)
WR_TIMEOUT, 255, cycles to wait for the missing AW/W half (used only with the optional feature)

Ports:
clk_main_a0  in  1  clock
rst_main_sync  in  1  synchronous active-high reset
s_awvalid/s_awready  in/out  1/1  write address handshake
s_awaddr  in  32  write byte address
s_wvalid/s_wready  in/out  1/1  write data handshake
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_bvalid/s_bready  out/in  1/1  write response handshake
s_bresp  out  2  write response
s_arvalid/s_arready  in/out  1/1  read address handshake
s_araddr  in  32  read byte address
s_rvalid/s_rready  out/in  1/1  read response handshake
s_rdata  out  32  read data
s_rresp  out  2  read response
reg_out  out  NUM_REGS*32  flattened RW register contents; reg i at [32i+31:32i]
vled_out  out  16  reg 0 [15:0]

Behaviour:
- Interface: one clock, clk_main_a0. Reset rst_main_sync is synchronous and active-high.
- Reset: all RW regs, both counters, bvalid, rvalid, bresp, rresp and rdata are 0. All ready outputs are 0 while reset is high. The cycle after reset deasserts, awready, wready and arready are 1.
- Decode: offset = addr - ADDR_BASE; idx = offset[31:2].
- Decode, valid region: idx < NUM_REGS selects an RW reg. idx == NUM_REGS selects CYCLE_CNT (RO). idx == NUM_REGS+1 selects WR_CNT (RO).
- Decode, errors: addr[1:0] != 0, addr < ADDR_BASE, or idx > NUM_REGS+1 give an error.
- Write FSM states: WR_IDLE, WR_WAIT_W (AW taken), WR_WAIT_AW (W taken), WR_RESP.
- Write ready rules: awready = 1 in WR_IDLE and WR_WAIT_AW. wready = 1 in WR_IDLE and WR_WAIT_W.
- Write transitions: AW and W both handshaking in WR_IDLE in the same cycle go directly to WR_RESP. When only one half arrives, latch it and enter the matching wait state. The second half moves the FSM to WR_RESP.
- Write commit: the register update happens on the edge where the write FSM enters WR_RESP. Per-byte strobes apply: wstrb 4'b0000 writes nothing but still responds OKAY.
- Write response: bvalid = 1 in WR_RESP, held with bresp stable until bready. Return to WR_IDLE on the handshake edge. No new AW/W is accepted during WR_RESP.
- Write response codes: bresp = 2'b00 (OKAY) for an RW hit. bresp = 2'b10 (SLVERR) for RO targets and decode errors, with no state change.
- WR_CNT: increments on every OKAY write commit and saturates at 32'hFFFF_FFFF.
- CYCLE_CNT: increments every cycle out of reset and wraps 32'hFFFF_FFFF -> 0.
- Read FSM states: RD_IDLE (arready = 1), RD_RESP (rvalid = 1).
- Read timing: the AR handshake captures rdata/rresp on the same edge, so rvalid is asserted the next cycle (1-cycle latency). rdata and rresp stay stable until rready. Return to RD_IDLE on the handshake edge, so the next AR can be accepted the following cycle.
- Read data: decode error gives rdata = 32'hDEAD_BEEF with rresp = 2'b10. Otherwise rresp = 2'b00.
- Read/write collision: if a read and a write commit target the same register on the same edge, the read returns the pre-write value.
- Read and write FSMs are fully independent; they may be in their response states simultaneously.
- Reset asserted mid-transaction: both FSMs go to idle, pending bvalid/rvalid drop to 0, and register contents clear to 0.

Optional Feature:
CL_OCL_AXIL_WR_TIMEOUT_EN.
- Defined: a 16-bit timer counts while the FSM is in WR_WAIT_W or WR_WAIT_AW. On reaching WR_TIMEOUT, the FSM enters WR_RESP with bresp = 2'b10 and no write. The missing half, if it arrives later, is accepted in WR_IDLE and treated as a new transaction.
- Not defined: the FSM waits indefinitely in the wait states; no timer logic is present.

Test Plan:
- Reset, then AW 0x500 and W 0xCAFE_F00D with strb 4'hF in the same cycle, bready = 1 -> bvalid 1 cycle later with bresp 0. reg_out[31:0] = 0xCAFEF00D, vled_out = 0xF00D. Read 0x500 -> rdata 0xCAFEF00D, rresp 0, rvalid 1 cycle after the AR handshake.
- W (0x1122_3344, strb 4'b0101) 3 cycles before AW 0x504 -> reg 1 = 0x0022_0044 starting from 0. Then AW 0x508 5 cycles before W -> committed only after W, bvalid follows.
- Write 0x520 (CYCLE_CNT) -> bresp 2'b10, no change. Read 0x52C (idx 11) and 0x502 -> rdata 0xDEADBEEF, rresp 2'b10. WR_CNT read at 0x524 equals the number of OKAY writes.
- Hold rready = 0 for 10 cycles on a read of 0x500 -> rvalid and rdata stable, arready = 0. Hold bready = 0 -> awready and wready stay 0 until the handshake.
- Same-edge read of 0x504 while a write of 0xFFFF_FFFF commits to 0x504 (old value 0x5) -> rdata 0x5; the next read returns 0xFFFFFFFF.
- With CL_OCL_AXIL_WR_TIMEOUT_EN and WR_TIMEOUT = 4: AW only -> bresp 2'b10 five cycles after the AW handshake, no register change. Reset asserted while in WR_RESP -> bvalid 0 the next cycle, all regs 0.
